// File: rtl/ser_field_writer_if.sv
// Request, status and DRAM byte-lane signals of the single-field writer.
interface ser_field_writer_if #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned VAL_W  = 64
);
    // Field request and write-point control
    logic                          en;
    logic [28:0]                   field_num;
    logic [2:0]                    wire_type;
    logic                          zigzag;
    logic [VAL_W-1:0]              value;
    logic                          wp_load;
    logic [ADDR_W-1:0]             wp_value;

    // Status
    logic                          ready;
    logic                          done;
    logic                          err;
    logic [ADDR_W-1:0]             write_point;

    // DRAM byte-lane port
    logic [LANES-1:0]              dram_en;
    logic                          dram_rdwr;
    logic [LANES-1:0][ADDR_W-1:0]  dram_addr;
    logic [LANES-1:0][7:0]         dram_data_out;
    logic [LANES-1:0]              dram_valid;

    modport slave (
        input  en, field_num, wire_type, zigzag, value, wp_load, wp_value, dram_valid,
        output ready, done, err, write_point, dram_en, dram_rdwr, dram_addr, dram_data_out
    );

    modport master (
        output en, field_num, wire_type, zigzag, value, wp_load, wp_value, dram_valid,
        input  ready, done, err, write_point, dram_en, dram_rdwr, dram_addr, dram_data_out
    );
endinterface

// File: rtl/ser_field_writer.sv
// Encodes one scalar protobuf field (tag + varint/zigzag/fixed32/fixed64 payload) and writes
// it downwards into a descending output buffer over a LANES-wide byte-lane DRAM port.
module ser_field_writer #(
    parameter int unsigned          LANES       = 8,
    parameter int unsigned          ADDR_W      = 64,
    parameter int unsigned          VAL_W       = 64,
    parameter logic [ADDR_W-1:0]    WRITE_TOP   = 'h300,
    parameter logic [ADDR_W-1:0]    WRITE_FLOOR = 'h200
) (
    input  logic              clk,
    input  logic              reset,
    ser_field_writer_if.slave bus
);
    // Varint payload bytes for a VAL_W value; fixed64 always needs 8 even when VAL_W=32,
    // so the buffer is sized for whichever is larger.
    localparam int unsigned VB       = (VAL_W + 6) / 7;
    localparam int unsigned PAY_B    = (VB > 8) ? VB : 8;
    localparam int unsigned BUF_B    = 5 + PAY_B;
    localparam int unsigned NBEAT    = (BUF_B + LANES - 1) / LANES;
    localparam int unsigned BUF_BITS = NBEAT * LANES * 8;
    localparam int unsigned LEN_W    = $clog2(BUF_B + 1);

    typedef enum logic [1:0] {StIdle, StEncode, StWrite, StDone} state_e;

    state_e                        state_q;
    logic                          ready_q, done_q, err_q, rdwr_q;
    logic [ADDR_W-1:0]             wp_q;
    logic [28:0]                   fnum_q;
    logic [2:0]                    wtype_q;
    logic                          zz_q;
    logic [VAL_W-1:0]              val_q;
    logic [BUF_BITS-1:0]           buf_q;
    logic [LEN_W-1:0]              len_q;
    logic [ADDR_W-1:0]             start_q;
    logic [7:0]                    beat_q;
    logic [LANES-1:0]              got_q;
    logic [LANES-1:0]              dram_en_q;
    logic [LANES-1:0][ADDR_W-1:0]  dram_addr_q;
    logic [LANES-1:0][7:0]         dram_data_q;

    // Encoder signals
    logic [34:0]                   tag_x;
    logic [2:0]                    tag_len;
    logic [4:0][7:0]               tag_b;
    logic [VAL_W-1:0]              vsrc;
    logic [7*VB-1:0]               var_x;
    logic [LEN_W-1:0]              var_len;
    logic [63:0]                   val64;
    logic [PAY_B-1:0][7:0]         pay_b;
    logic [LEN_W-1:0]              pay_len;
    logic [BUF_B-1:0][7:0]         enc_buf;
    logic [LEN_W-1:0]              enc_len;
    logic [ADDR_W-1:0]             enc_start;
    logic                          enc_err;

    // Beat generation signals
    logic [BUF_BITS-1:0]           src_buf;
    logic [LEN_W-1:0]              src_len;
    logic [ADDR_W-1:0]             src_start;
    logic [7:0]                    src_beat;
    logic [BUF_BITS-1:0]           shifted;
    logic [LANES-1:0]              lane_en;
    logic [LANES-1:0][ADDR_W-1:0]  lane_addr;
    logic [LANES-1:0][7:0]         lane_data;
    logic [LANES-1:0]              lanes_done;
    logic                          beat_done;
    logic                          is_last;

    // Tag and payload encoding from the latched request
    always_comb begin
        tag_x   = {3'b000, fnum_q, wtype_q};
        tag_len = 3'd1;
        for (int j = 1; j < 5; j++) begin
            if ((tag_x >> (7 * j)) != '0) tag_len = 3'(j + 1);
        end
        for (int j = 0; j < 5; j++) begin
            tag_b[j] = {(j + 1 < int'(tag_len)), tag_x[7*j +: 7]};
        end

        vsrc = zz_q ? ((val_q << 1) ^ {VAL_W{val_q[VAL_W-1]}}) : val_q;
        var_x = '0;
        var_x[VAL_W-1:0] = vsrc;
        var_len = LEN_W'(1);
        for (int j = 1; j < int'(VB); j++) begin
            if ((var_x >> (7 * j)) != '0) var_len = LEN_W'(j + 1);
        end

        val64 = '0;
        val64[VAL_W-1:0] = val_q;
        pay_b   = '0;
        pay_len = '0;
        case (wtype_q)
            3'd0: begin
                for (int j = 0; j < int'(VB); j++) begin
                    pay_b[j] = {(j + 1 < int'(var_len)), var_x[7*j +: 7]};
                end
                pay_len = var_len;
            end
            3'd1: begin
                for (int j = 0; j < 8; j++) pay_b[j] = val64[8*j +: 8];
                pay_len = LEN_W'(8);
            end
            3'd5: begin
                for (int j = 0; j < 4; j++) pay_b[j] = val64[8*j +: 8];
                pay_len = LEN_W'(4);
            end
            default: pay_len = '0;
        endcase

        // Tag bytes first, payload packed immediately after
        enc_buf = '0;
        for (int j = 0; j < 5; j++) begin
            if (j < int'(tag_len)) enc_buf[j] = tag_b[j];
        end
        for (int t = 1; t <= 5; t++) begin
            if (int'(tag_len) == t) begin
                for (int k = 0; k < int'(PAY_B); k++) enc_buf[t+k] = pay_b[k];
            end
        end
        enc_len   = LEN_W'(tag_len) + pay_len;
        enc_start = wp_q - ADDR_W'(enc_len) + ADDR_W'(1);

        // Room check written as len-1 > wp-floor so it cannot wrap
        enc_err = !(wtype_q == 3'd0 || wtype_q == 3'd1 || wtype_q == 3'd5) ||
                  (fnum_q == '0) || (wp_q < WRITE_FLOOR) ||
                  ((ADDR_W'(enc_len) - ADDR_W'(1)) > (wp_q - WRITE_FLOOR));
    end

    // Lane enables/addresses/data for the beat about to be issued
    always_comb begin
        if (state_q == StEncode) begin
            src_buf   = BUF_BITS'(enc_buf);
            src_len   = enc_len;
            src_start = enc_start;
            src_beat  = 8'd0;
        end else begin
            src_buf   = buf_q;
            src_len   = len_q;
            src_start = start_q;
            src_beat  = beat_q + 8'd1;
        end
        shifted = src_buf >> (32'(src_beat) * LANES * 8);
        for (int i = 0; i < int'(LANES); i++) begin
            int unsigned b;
            b            = 32'(src_beat) * LANES + 32'(i);
            lane_en[i]   = b < 32'(src_len);
            lane_addr[i] = lane_en[i] ? (src_start + ADDR_W'(b)) : '0;
            lane_data[i] = lane_en[i] ? shifted[8*i +: 8] : 8'h00;
        end
        lanes_done = got_q | (bus.dram_valid & dram_en_q);
        beat_done  = (lanes_done == dram_en_q);
        is_last    = ((32'(beat_q) + 32'd1) * LANES) >= 32'(len_q);
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdwr_q      <= 1'b0;
            wp_q        <= WRITE_TOP;
            fnum_q      <= '0;
            wtype_q     <= '0;
            zz_q        <= 1'b0;
            val_q       <= '0;
            buf_q       <= '0;
            len_q       <= '0;
            start_q     <= '0;
            beat_q      <= '0;
            got_q       <= '0;
            dram_en_q   <= '0;
            dram_addr_q <= '0;
            dram_data_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.wp_load) begin
                        wp_q <= bus.wp_value;
                    end else if (bus.en) begin
                        fnum_q  <= bus.field_num;
                        wtype_q <= bus.wire_type;
                        zz_q    <= bus.zigzag;
                        val_q   <= bus.value;
                        ready_q <= 1'b0;
                        state_q <= StEncode;
                    end
                end
                StEncode: begin
                    if (enc_err) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        buf_q       <= BUF_BITS'(enc_buf);
                        len_q       <= enc_len;
                        start_q     <= enc_start;
                        beat_q      <= 8'd0;
                        got_q       <= '0;
                        dram_en_q   <= lane_en;
                        dram_addr_q <= lane_addr;
                        dram_data_q <= lane_data;
                        rdwr_q      <= 1'b1;
                        state_q     <= StWrite;
                    end
                end
                StWrite: begin
                    if (beat_done) begin
                        got_q <= '0;
                        if (is_last) begin
                            dram_en_q   <= '0;
                            dram_addr_q <= '0;
                            dram_data_q <= '0;
                            rdwr_q      <= 1'b0;
                            done_q      <= 1'b1;
                            err_q       <= 1'b0;
                            state_q     <= StDone;
                        end else begin
                            beat_q      <= beat_q + 8'd1;
                            dram_en_q   <= lane_en;
                            dram_addr_q <= lane_addr;
                            dram_data_q <= lane_data;
                        end
                    end else begin
                        // Lanes may finish on different cycles; remember the ones that have
                        got_q <= lanes_done;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    if (!err_q) wp_q <= start_q - ADDR_W'(1);
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready         = ready_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.write_point   = wp_q;
    assign bus.dram_en       = dram_en_q;
    assign bus.dram_rdwr     = rdwr_q;
    assign bus.dram_addr     = dram_addr_q;
    assign bus.dram_data_out = dram_data_q;
endmodule

// File: tb/tb_ser_field_writer.sv
// Scoreboard bench for ser_field_writer: stimulus pushes expected beats/completions,
// independent monitors act as the DRAM and compare what the writer presents.
module tb_ser_field_writer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ser_field_writer_if #(.LANES(8), .ADDR_W(64), .VAL_W(64)) dif ();

    ser_field_writer #(
        .LANES(8), .ADDR_W(64), .VAL_W(64), .WRITE_TOP(64'h300), .WRITE_FLOOR(64'h200)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    typedef struct {
        logic [7:0]  en;
        logic [63:0] base;
        logic [63:0] data;
    } beat_t;
    typedef struct {
        logic        err;
        logic [63:0] wp;
    } done_t;

    beat_t exp_beats[$];
    done_t exp_done[$];
    int checks = 0;
    int failures = 0;
    bit slow = 0;
    bit stray = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lat(input int i);
        return slow ? ((i < 4) ? 1 : 3) : 0;
    endfunction

    task automatic push_beat(input logic [7:0] en, input logic [63:0] base,
                             input logic [63:0] data);
        beat_t b;
        b.en = en; b.base = base; b.data = data;
        exp_beats.push_back(b);
    endtask

    task automatic push_done(input logic err, input logic [63:0] wp);
        done_t d;
        d.err = err; d.wp = wp;
        exp_done.push_back(d);
    endtask

    // DRAM model and beat monitor
    initial begin
        bit               in_beat;
        bit               beat_fin;
        int               age;
        logic [7:0]       snap_en;
        logic [7:0][63:0] snap_addr;
        logic [63:0]      snap_data;
        logic [7:0]       dv;
        beat_t            b;
        in_beat = 0; beat_fin = 0; age = 0;
        dif.dram_valid = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_beat = 0;
                beat_fin = 0;
                dif.dram_valid = '0;
            end else begin
                if (in_beat && beat_fin) in_beat = 0;
                if (in_beat) begin
                    age++;
                    check("beat_hold", 64'(dif.dram_en == snap_en && dif.dram_addr == snap_addr &&
                                           dif.dram_data_out == snap_data), 64'd1);
                end else if (dif.dram_en != '0) begin
                    if (exp_beats.size() == 0) begin
                        check("unexpected_beat", 64'(dif.dram_en), 64'd0);
                    end else begin
                        logic [63:0] act_d;
                        logic [63:0] bad_addr;
                        logic [63:0] want_addr;
                        b = exp_beats.pop_front();
                        check("beat_en", 64'(dif.dram_en), 64'(b.en));
                        check("beat_rdwr", 64'(dif.dram_rdwr), 64'd1);
                        act_d = '0;
                        bad_addr = b.base;
                        want_addr = b.base;
                        for (int i = 0; i < 8; i++) begin
                            if (b.en[i]) begin
                                act_d[8*i +: 8] = dif.dram_data_out[i];
                                if (dif.dram_addr[i] != b.base + 64'(i)) begin
                                    bad_addr = dif.dram_addr[i];
                                    want_addr = b.base + 64'(i);
                                end
                            end
                        end
                        check("beat_addr", bad_addr, want_addr);
                        check("beat_data", act_d, b.data);
                    end
                    snap_en = dif.dram_en;
                    snap_addr = dif.dram_addr;
                    snap_data = dif.dram_data_out;
                    age = 0;
                    in_beat = 1;
                end
                dv = '0;
                if (in_beat) begin
                    beat_fin = 1;
                    for (int i = 0; i < 8; i++) begin
                        if (snap_en[i]) begin
                            if (age == lat(i)) dv[i] = 1'b1;
                            if (age < lat(i)) beat_fin = 0;
                        end
                    end
                end else if (stray) begin
                    dv = '1;
                end
                dif.dram_valid = dv;
            end
        end
    end

    // Completion monitor
    initial begin
        done_t d;
        forever begin
            @(negedge clk);
            if (reset && dif.done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 64'(dif.done), 64'd0);
                end else begin
                    d = exp_done.pop_front();
                    check("done_err", 64'(dif.err), 64'(d.err));
                    @(negedge clk);
                    check("done_pulse", 64'(dif.done), 64'd0);
                    check("done_wp", dif.write_point, d.wp);
                    check("done_ready", 64'(dif.ready), 64'd1);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!dif.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dif.ready) check("ready_timeout", 64'(dif.ready), 64'd1);
    endtask

    task automatic send(input logic [28:0] fn, input logic [2:0] wt, input logic zz,
                        input logic [63:0] val);
        @(negedge clk);
        dif.field_num = fn; dif.wire_type = wt; dif.zigzag = zz; dif.value = val;
        dif.en = 1'b1;
        @(negedge clk);
        dif.en = 1'b0;
        dif.field_num = '0; dif.wire_type = 3'd7; dif.value = '0;
        check("ready_drop", 64'(dif.ready), 64'd0);
        wait_ready();
    endtask

    task automatic load_wp(input logic [63:0] v);
        @(negedge clk);
        dif.wp_load = 1'b1; dif.wp_value = v;
        @(negedge clk);
        dif.wp_load = 1'b0;
        check("wp_load", dif.write_point, v);
    endtask

    initial begin
        dif.en = 0; dif.field_num = '0; dif.wire_type = '0; dif.zigzag = 0; dif.value = '0;
        dif.wp_load = 0; dif.wp_value = '0;
        #12;
        check("rst_ready", 64'(dif.ready), 64'd1);
        check("rst_done", 64'(dif.done), 64'd0);
        check("rst_err", 64'(dif.err), 64'd0);
        check("rst_dram_en", 64'(dif.dram_en), 64'd0);
        check("rst_rdwr", 64'(dif.dram_rdwr), 64'd0);
        check("rst_addr0", dif.dram_addr[0], 64'd0);
        check("rst_wp", dif.write_point, 64'h300);
        @(negedge clk);
        reset = 1'b1;

        // varint 150
        push_beat(8'h07, 64'h2FE, 64'h0000_0000_0001_9608);
        push_done(1'b0, 64'h2FD);
        send(29'd1, 3'd0, 1'b0, 64'd150);
        // zigzag -1
        push_beat(8'h03, 64'h2FC, 64'h0000_0000_0000_0110);
        push_done(1'b0, 64'h2FB);
        send(29'd2, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        // 12-byte varint, two beats, staggered lane completion
        load_wp(64'h2FA);
        slow = 1;
        push_beat(8'hFF, 64'h2EF, 64'hFFFF_FFFF_FFFF_0180);
        push_beat(8'h0F, 64'h2F7, 64'h0000_0000_01FF_FFFF);
        push_done(1'b0, 64'h2EE);
        send(29'd16, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        slow = 0;
        // fixed32
        push_beat(8'h1F, 64'h2EA, 64'h0000_00DE_ADBE_EF1D);
        push_done(1'b0, 64'h2E9);
        send(29'd3, 3'd5, 1'b0, 64'h0000_0000_DEAD_BEEF);
        // fixed64 spanning two beats
        push_beat(8'hFF, 64'h2E1, 64'h0203_0405_0607_0809);
        push_beat(8'h01, 64'h2E9, 64'h0000_0000_0000_0001);
        push_done(1'b0, 64'h2E0);
        send(29'd1, 3'd1, 1'b0, 64'h0102_0304_0506_0708);
        // maximum field number, 5-byte tag
        push_beat(8'h3F, 64'h2DB, 64'h0000_000F_FFFF_FFF8);
        push_done(1'b0, 64'h2DA);
        send(29'h1FFF_FFFF, 3'd0, 1'b0, 64'd0);

        // error cases, with stray dram_valid while idle
        stray = 1;
        push_done(1'b1, 64'h2DA);
        send(29'd1, 3'd2, 1'b0, 64'd5);
        push_done(1'b1, 64'h2DA);
        send(29'd0, 3'd0, 1'b0, 64'd5);
        load_wp(64'h201);
        push_done(1'b1, 64'h201);
        send(29'd1, 3'd0, 1'b0, 64'd150);
        stray = 0;
        // exactly fits down to the floor
        load_wp(64'h202);
        push_beat(8'h07, 64'h200, 64'h0000_0000_0001_9608);
        push_done(1'b0, 64'h1FF);
        send(29'd1, 3'd0, 1'b0, 64'd150);

        // load and request in the same cycle: load wins
        @(negedge clk);
        dif.wp_load = 1'b1; dif.wp_value = 64'h280;
        dif.en = 1'b1; dif.field_num = 29'd1; dif.wire_type = 3'd0; dif.value = 64'd150;
        @(negedge clk);
        dif.wp_load = 1'b0; dif.en = 1'b0;
        check("load_wins_ready", 64'(dif.ready), 64'd1);
        check("load_wins_wp", dif.write_point, 64'h280);
        repeat (6) @(negedge clk);
        check("load_wins_idle", 64'(dif.ready), 64'd1);

        // reset during beat 1 of the 12-byte field
        load_wp(64'h2FA);
        slow = 1;
        push_beat(8'hFF, 64'h2EF, 64'hFFFF_FFFF_FFFF_0180);
        push_beat(8'h0F, 64'h2F7, 64'h0000_0000_01FF_FFFF);
        @(negedge clk);
        dif.field_num = 29'd16; dif.wire_type = 3'd0; dif.zigzag = 0;
        dif.value = 64'hFFFF_FFFF_FFFF_FFFF; dif.en = 1'b1;
        @(negedge clk);
        dif.en = 1'b0;
        begin
            int n = 0;
            while (dif.dram_en != 8'h0F && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("beat1_seen", 64'(dif.dram_en), 64'h0F);
        end
        #2 reset = 1'b0;
        #1;
        check("rst_mid_dram_en", 64'(dif.dram_en), 64'd0);
        check("rst_mid_ready", 64'(dif.ready), 64'd1);
        check("rst_mid_wp", dif.write_point, 64'h300);
        check("rst_mid_done", 64'(dif.done), 64'd0);
        slow = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("beats_left", 64'(exp_beats.size()), 64'd0);
        check("dones_left", 64'(exp_done.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
